// File: rtl/bin2bcd_seq.sv
// 8-bit binary to 3-digit packed BCD, shift-and-add-3, one bit per clock.
// Result and done pulse 8 cycles after the accepting edge; start is ignored while busy (no queuing).
module bin2bcd_seq (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic [11:0] bcd,
  output logic        busy,
  output logic        done
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_CONV = 1'b1;

  logic        state;
  logic [2:0]  cnt;
  logic [7:0]  sreg;
  logic [11:0] dig;
  logic [11:0] dig_adj;
  logic [19:0] cat_shift;

  function automatic logic [3:0] adj3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Hundreds correction can never fire for 8-bit inputs but is kept for uniformity.
  always_comb begin
    dig_adj   = {adj3(dig[11:8]), adj3(dig[7:4]), adj3(dig[3:0])};
    cat_shift = {dig_adj, sreg} << 1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= S_IDLE;
      cnt   <= 3'd0;
      sreg  <= 8'd0;
      dig   <= 12'd0;
      bcd   <= 12'd0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sreg  <= bin;
            dig   <= 12'd0;
            cnt   <= 3'd0;
            state <= S_CONV;
          end
        end
        default: begin
          dig  <= cat_shift[19:8];
          sreg <= cat_shift[7:0];
          cnt  <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            bcd   <= cat_shift[19:8];
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy = state;

endmodule
